// File: rtl/pfb_snap_capture_ctrl_pkg.sv
// Shared types and sizing for the PFB snapshot capture controller.
// SNAP_PRETRIG_EN (optional) uses POST_TRIG_WORDS for the post-trigger capture length.
package pfb_snap_pkg;

  localparam int unsigned SNAP_DATA_W = 64;
  localparam int unsigned SNAP_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } snap_state_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned post_words_of(input int unsigned aw);
    return depth_of(aw) >> 1;
  endfunction

  localparam int unsigned DEPTH           = depth_of(SNAP_ADDR_W);
  localparam int unsigned POST_TRIG_WORDS = post_words_of(SNAP_ADDR_W);

endpackage

// File: rtl/pfb_snap_capture_ctrl_if.sv
// Control, sample stream, BRAM port A and status bundle of the snapshot controller.
// With SNAP_PRETRIG_EN the bundle also carries status_trig_addr.
interface pfb_snap_capture_ctrl_if
  import pfb_snap_pkg::*;
#(
  parameter int unsigned DATA_W = SNAP_DATA_W,
  parameter int unsigned ADDR_W = SNAP_ADDR_W
);
  logic              ctrl_arm;
  logic              ctrl_trig_sel;
  logic              trig;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              bram_we;
  logic              bram_en_a;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wr_data;
  logic              status_busy;
  logic              status_done;
  logic [ADDR_W:0]   status_count;
`ifdef SNAP_PRETRIG_EN
  logic [ADDR_W-1:0] status_trig_addr;
`endif

  // slave: the capture controller; master: software/stream side
  modport slave (
`ifdef SNAP_PRETRIG_EN
    output status_trig_addr,
`endif
    input  ctrl_arm, ctrl_trig_sel, trig, din_valid, din,
    output bram_we, bram_en_a, bram_addr, bram_wr_data,
    output status_busy, status_done, status_count
  );

  modport master (
`ifdef SNAP_PRETRIG_EN
    input  status_trig_addr,
`endif
    output ctrl_arm, ctrl_trig_sel, trig, din_valid, din,
    input  bram_we, bram_en_a, bram_addr, bram_wr_data,
    input  status_busy, status_done, status_count
  );

endinterface

// File: rtl/pfb_snap_capture_ctrl_edge_det.sv
// Rising-edge detector for the software arm bit; one-cycle pulse per 0->1 transition.
module snap_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/pfb_snap_capture_ctrl.sv
// Snapshot capture sequencer: arm, trigger, then write one buffer of valid samples to BRAM port A.
// Optional SNAP_PRETRIG_EN: circular pre-trigger fill, half-buffer post-trigger capture.
//
// state      | meaning
// IDLE       | waiting for the first arm edge after reset
// ARMED      | waiting for trigger (pre-trigger fill when enabled)
// CAPTURE    | writing post-trigger samples
// DONE       | buffer complete, holding until re-armed
module pfb_snap_capture_ctrl
  import pfb_snap_pkg::*;
#(
  parameter int unsigned DATA_W = SNAP_DATA_W,
  parameter int unsigned ADDR_W = SNAP_ADDR_W
) (
  input logic                    clk,
  input logic                    rst,
  pfb_snap_capture_ctrl_if.slave bus
);

`ifdef SNAP_PRETRIG_EN
  localparam int unsigned CAP_WORDS = post_words_of(ADDR_W);
`else
  localparam int unsigned CAP_WORDS = depth_of(ADDR_W);
`endif
  localparam logic [ADDR_W-1:0] CAP_LOAD  = ADDR_W'(CAP_WORDS - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(depth_of(ADDR_W));

  snap_state_t       state_q, state_d;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_data_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] cap_left_q;
  logic              arm_rise;
  logic              wr_d;
  logic              post_wr;
  logic              load;
`ifdef SNAP_PRETRIG_EN
  logic              trig_hit;
  logic [ADDR_W-1:0] trig_addr_q;
`endif

  snap_edge_det u_arm_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.ctrl_arm),
    .rise_o (arm_rise)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    post_wr = 1'b0;
    load    = 1'b0;
`ifdef SNAP_PRETRIG_EN
    trig_hit = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_rise) begin
          state_d = ST_ARMED;
          load    = 1'b1;
        end
      end
      ST_ARMED: begin
        // the sample present in the trigger cycle is the first post-trigger word
        if (bus.ctrl_trig_sel || bus.trig) begin
          state_d = ST_CAPTURE;
          post_wr = bus.din_valid;
`ifdef SNAP_PRETRIG_EN
          trig_hit = 1'b1;
`endif
        end
`ifdef SNAP_PRETRIG_EN
        wr_d = bus.din_valid;
`else
        wr_d = post_wr;
`endif
      end
      ST_CAPTURE: begin
        post_wr = bus.din_valid;
        wr_d    = post_wr;
      end
      default: state_d = ST_IDLE;
    endcase
    if (post_wr && (cap_left_q == '0)) state_d = ST_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cap_left_q  <= '0;
`ifdef SNAP_PRETRIG_EN
      trig_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bram_we_q <= wr_d;
      if (load) begin
        wr_ptr_q   <= '0;
        count_q    <= '0;
        cap_left_q <= CAP_LOAD;
      end
      if (wr_d) begin
        bram_addr_q <= wr_ptr_q;
        bram_data_q <= bus.din;
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
      end
      if (post_wr && (cap_left_q != '0)) cap_left_q <= cap_left_q - 1'b1;
`ifdef SNAP_PRETRIG_EN
      if (trig_hit) trig_addr_q <= wr_ptr_q;
`endif
    end
  end

  assign bus.bram_we      = bram_we_q;
  assign bus.bram_en_a    = bram_we_q;
  assign bus.bram_addr    = bram_addr_q;
  assign bus.bram_wr_data = bram_data_q;
  assign bus.status_busy  = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign bus.status_done  = (state_q == ST_DONE);
  assign bus.status_count = count_q;
`ifdef SNAP_PRETRIG_EN
  assign bus.status_trig_addr = trig_addr_q;
`endif

endmodule
